scfifo_wr_arbiter: RTL
======================

# scfifo_wr_arbiter

Round-robin write arbiter that shares one `scfifo` write port between `NUM_REQ` producers. Each producer has a valid/ready handshake. The block grants one producer at a time for a bounded burst. It uses the FIFO's `full`/`usedw` to guarantee the FIFO never overflows. It sits directly in front of an `scfifo`/`scfifo_legacy` instance and drives its `wrreq` and `data` pins from registers.

## Interface
- `WIDTH`, 20, data word width.
- `NUM_REQ`, 4, number of producers (≥2).
- `LOG_DEPTH`, 5, width of FIFO `usedw`.
- `NUM_WORDS`, 2**LOG_DEPTH, FIFO capacity (`lpm_numwords`).
- `MAX_BURST`, 8, maximum words per grant (≥1).

Ports:
- `clock`  in  1  sole clock.
- `aclr_n`  in  1  asynchronous reset, active-low.
- `req_valid`  in  NUM_REQ  per-producer word valid.
- `req_data`  in  NUM_REQ*WIDTH  producer i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NUM_REQ  per-producer accept; combinational.
- `fifo_full`  in  1  FIFO `full`.
- `fifo_usedw`  in  LOG_DEPTH  FIFO `usedw`.
- `fifo_wrreq`  out  1  registered FIFO write request.
- `fifo_data`  out  WIDTH  registered FIFO write data.
- `grant`  out  NUM_REQ  registered one-hot grant; all-zero in IDLE.
- `busy`  out  1  high in BURST.

## Operation
- Reset (`aclr_n`=0, asynchronous) sets all outputs and state to known values:
  - state=IDLE; `grant`=0; `fifo_wrreq`=0; `fifo_data`=0; `req_ready`=0; `busy`=0.
  - Round-robin pointer `ptr`=0; burst counter=0.
- Free-space accounting:
  - occ = `fifo_full` ? NUM_WORDS : `fifo_usedw`.
  - free = NUM_WORDS − occ − `fifo_wrreq`. The in-flight registered write is counted.
  - space_ok = (free > 0). Arithmetic is LOG_DEPTH+1 bits, unsigned, and never underflows.
- IDLE:
  - If any `req_valid` is high, select the first valid index searching `ptr`, `ptr`+1, … with wrap modulo NUM_REQ.
  - Register its one-hot `grant`, clear the burst counter, and go to BURST.
  - No word is accepted in IDLE, which costs one bubble cycle per grant.
- BURST, with granted index g:
  - `req_ready[g]` = space_ok. All other `req_ready` bits are 0.
  - Accept when `req_valid[g]` & `req_ready[g]`. The burst counter then increments.
  - Stall when `req_valid[g]`=1 and space_ok=0: stay in BURST and hold the counter and grant.
  - End the burst after an accept with counter = MAX_BURST−1, or in any cycle with `req_valid[g]`=0 (no accept that cycle).
  - On burst end: go to IDLE, set `grant` to 0, and set `ptr` = (g+1) mod NUM_REQ.
- Producers must hold `req_data` stable while valid is high and not yet accepted.
- Words from one producer reach the FIFO in acceptance order. Bursts from different producers never interleave.

## Timing
- Acceptance at cycle t gives `fifo_wrreq`=1 and `fifo_data`=accepted word at cycle t+1. Otherwise `fifo_wrreq`=0 at t+1 and `fifo_data` holds its value.
- `grant` and `busy` update one cycle after the IDLE decision.
- Peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
- Back-to-back accepts are allowed every cycle within a burst while space_ok holds.
- Deasserting `aclr_n` mid-burst drops the in-flight grant immediately. Any word accepted in the cycle before reset is lost.
- Reset release is synchronised externally. The first IDLE decision occurs on the first `clock` edge after release.

## Configuration
- `SCFIFO_ARB_BURST_EN` defined: `MAX_BURST` is honoured as above.
- Undefined: the effective burst length is 1. Every grant carries exactly one word, then returns to IDLE and advances `ptr`. The burst counter is not built.

## Test plan
- Reset: assert `aclr_n`=0 during a BURST with `grant`=0100 → asynchronously `grant`=0, `fifo_wrreq`=0, `busy`=0, `req_ready`=0. After release, with all producers valid, producer 0 is granted first.
- Single producer: NUM_REQ=4, MAX_BURST=8, only producer 1 valid with words 10, 11, 12, then valid low → `grant`=0010 one cycle after valid rises. Then `fifo_wrreq`=1 on three consecutive cycles carrying 10, 11, 12. Then IDLE with `grant`=0 and `ptr`=2.
- Fairness: all four producers continuously valid, MAX_BURST=4 → grants cycle 0001, 0010, 0100, 1000, 0001, each with exactly 4 writes. There is 1 idle cycle between grants.
- Full boundary: NUM_WORDS=32, `fifo_usedw`=31 → exactly one word accepted, then `req_ready` stays 0 (in-flight write counted, `fifo_full` rises). A FIFO read restores `usedw`=31 and acceptance resumes. No overflow ever occurs.
- Wrap priority: `ptr`=3, producers 0 and 3 valid → producer 3 granted first. After its burst, producer 0 is granted.
- Macro undefined: all producers valid → each grant carries one word. Grants rotate 0001, 0010, 0100, 1000 on every other cycle.

Source files
------------

// File: rtl/scfifo_wr_arbiter.sv
// Round-robin write arbiter sharing one scfifo write port between NUM_REQ producers.
// Define SCFIFO_ARB_BURST_EN to allow up to MAX_BURST words per grant; otherwise one word per grant.
module scfifo_wr_arbiter #(
  parameter int WIDTH     = 20,
  parameter int NUM_REQ   = 4,
  parameter int LOG_DEPTH = 5,
  parameter int NUM_WORDS = 2**LOG_DEPTH,
  parameter int MAX_BURST = 8
) (
  input  logic                     clock,
  input  logic                     aclr_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  input  logic [LOG_DEPTH-1:0]     fifo_usedw,
  output logic                     fifo_wrreq,
  output logic [WIDTH-1:0]         fifo_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OW = LOG_DEPTH + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               wrreq_q, wrreq_d;
  logic [WIDTH-1:0]   data_q, data_d;

  // The registered write still in flight is counted as occupied.
  logic [OW-1:0] occ;
  logic [OW-1:0] used_tot;
  logic          space_ok;

  assign occ      = fifo_full ? OW'(NUM_WORDS) : {1'b0, fifo_usedw};
  assign used_tot = occ + OW'(wrreq_q);
  assign space_ok = (used_tot < OW'(NUM_WORDS));

  // Round-robin pick: lowest valid index at or above ptr, else lowest valid overall.
  logic [NUM_REQ-1:0] hi_oh, lo_oh, sel_oh;
  logic               found_hi, found_lo;

  always_comb begin
    hi_oh    = '0;
    lo_oh    = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !found_lo) begin
        lo_oh[i] = 1'b1;
        found_lo = 1'b1;
      end
      if (req_valid[i] && (i >= int'(ptr_q)) && !found_hi) begin
        hi_oh[i] = 1'b1;
        found_hi = 1'b1;
      end
    end
    sel_oh = found_hi ? hi_oh : lo_oh;
  end

  logic             g_valid;
  logic [WIDTH-1:0] g_data;
  logic [PW-1:0]    g_next_ptr;
  logic             accept;
  logic             last_word;

  always_comb begin
    g_valid    = 1'b0;
    g_data     = '0;
    g_next_ptr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        g_valid    = req_valid[i];
        g_data     = req_data[i*WIDTH +: WIDTH];
        g_next_ptr = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  assign accept = (state_q == S_BURST) && g_valid && space_ok;

`ifdef SCFIFO_ARB_BURST_EN
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  assign last_word = (cnt_q == CW'(MAX_BURST - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Every legal MAX_BURST collapses to a single word per grant here.
  assign last_word = (MAX_BURST > 0);
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    wrreq_d   = 1'b0;
    data_d    = data_q;
    req_ready = '0;
    if (state_q == S_IDLE) begin
      if (|req_valid) begin
        grant_d = sel_oh;
        state_d = S_BURST;
      end
    end else begin
      req_ready = space_ok ? grant_q : '0;
      wrreq_d   = accept;
      if (accept) begin
        data_d = g_data;
      end
      if ((accept && last_word) || !g_valid) begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = g_next_ptr;
      end
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      wrreq_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wrreq_q <= wrreq_d;
      data_q  <= data_d;
    end
  end

  assign fifo_wrreq = wrreq_q;
  assign fifo_data  = data_q;
  assign grant      = grant_q;
  assign busy       = (state_q == S_BURST);

endmodule
